// File: rtl/seq_divider_pkg.sv
// Shared definitions for the iterative divider.
//   state_t : controller states (IDLE, CALC, FIX, DONE), with fixed 2-bit codes
//   STEPS   : number of restoring steps (one quotient bit per cycle)
//   CNT_W   : width of the step counter
package seq_divider_pkg;

  localparam int unsigned STEPS = 32;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_divider_step.sv
// div_step: one combinational restoring-division step.
//   i_rem : current partial remainder (WIDTH+1 bits)
//   i_bit : next dividend bit, MSB first
//   i_div : divisor magnitude
//   o_rem : new partial remainder
//   o_q   : quotient bit produced by this step
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH:0]   o_rem,
  output logic             o_q
);

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH:0]   w_diff;

  always_comb begin
    w_shift = {i_rem, i_bit};
    w_diff  = w_shift[WIDTH:0] - {1'b0, i_div};
    // Trial subtraction succeeds when the shifted remainder is not below the divisor
    o_q     = (w_shift >= {2'b00, i_div});
    o_rem   = o_q ? w_diff : w_shift[WIDTH:0];
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative signed (floored) / unsigned integer divider.
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   start      : begin a division; accepted in IDLE or DONE only
//   u          : 1 = unsigned, 0 = signed with floored semantics
//   x, y       : dividend, divisor (sampled with an accepted start)
//   busy       : operation in progress (CALC and FIX)
//   done       : one-cycle result-valid pulse
//   dz         : last operation divided by zero
//   quot, rem  : results, held until overwritten by the next operation
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             u,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_u;
  logic             r_sx;
  logic             r_sy;
  logic             r_yz;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_yabs;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH:0]   r_prem;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
  logic             r_dz;

  logic             w_accept;
  logic             w_xneg;
  logic             w_yneg;
  logic [WIDTH-1:0] w_xabs;
  logic [WIDTH-1:0] w_yabs;
  logic [WIDTH:0]   w_step_rem;
  logic             w_step_q;
  logic [WIDTH-1:0] w_ra;
  logic             w_ra_nz;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  assign w_accept = start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
  assign w_xneg   = ~u & x[WIDTH-1];
  assign w_yneg   = ~u & y[WIDTH-1];
  assign w_xabs   = w_xneg ? ('0 - x) : x;
  assign w_yabs   = w_yneg ? ('0 - y) : y;

  // The dividend register shifts out dividend bits at the top and collects
  // quotient bits at the bottom, so after all steps it holds |quotient|.
  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_prem),
    .i_bit (r_dvd[WIDTH-1]),
    .i_div (r_yabs),
    .o_rem (w_step_rem),
    .o_q   (w_step_q)
  );

  assign w_ra    = r_prem[WIDTH-1:0];
  assign w_ra_nz = |r_prem;

  // Sign correction from magnitudes to floored results (remainder follows
  // the divisor's sign). Divide-by-zero overrides with all-ones / dividend.
  always_comb begin
    w_q_fix = r_dvd;
    w_r_fix = w_ra;
    if (r_yz) begin
      w_q_fix = '1;
      w_r_fix = r_x;
    end else if (!r_u) begin
      if (r_sx == r_sy) begin
        w_q_fix = r_dvd;
        w_r_fix = r_sy ? ('0 - w_ra) : w_ra;
      end else if (!w_ra_nz) begin
        w_q_fix = '0 - r_dvd;
        w_r_fix = '0;
      end else begin
        // -qa - 1 is the bitwise complement of qa
        w_q_fix = ~r_dvd;
        w_r_fix = r_sy ? (w_ra - r_yabs) : (r_yabs - w_ra);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_u     <= 1'b0;
      r_sx    <= 1'b0;
      r_sy    <= 1'b0;
      r_yz    <= 1'b0;
      r_x     <= '0;
      r_yabs  <= '0;
      r_dvd   <= '0;
      r_prem  <= '0;
      r_quot  <= '0;
      r_remo  <= '0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_state <= ST_CALC;
            r_cnt   <= '0;
            r_u     <= u;
            r_sx    <= x[WIDTH-1];
            r_sy    <= y[WIDTH-1];
            r_yz    <= (y == '0);
            r_x     <= x;
            r_yabs  <= w_yabs;
            r_dvd   <= w_xabs;
            r_prem  <= '0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          r_prem <= w_step_rem;
          r_dvd  <= {r_dvd[WIDTH-2:0], w_step_q};
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == LAST_STEP) begin
            r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          r_quot  <= w_q_fix;
          r_remo  <= w_r_fix;
          r_dz    <= r_yz;
          r_state <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (r_state == ST_CALC) | (r_state == ST_FIX);
  assign done = (r_state == ST_DONE);
  assign dz   = r_dz;
  assign quot = r_quot;
  assign rem  = r_remo;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic        u;
  logic [31:0] x;
  logic [31:0] y;
  logic        busy;
  logic        done;
  logic        dz;
  logic [31:0] quot;
  logic [31:0] rem;

  int unsigned n_tests;
  int unsigned n_fail;

  seq_divider #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .u     (u),
    .x     (x),
    .y     (y),
    .busy  (busy),
    .done  (done),
    .dz    (dz),
    .quot  (quot),
    .rem   (rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present operands with start in the current cycle (cycle 0); returns in
  // cycle 1 with operands scrambled so later changes are seen to be ignored.
  task automatic launch(input logic iu, input logic [31:0] ix, input logic [31:0] iy);
    u = iu; x = ix; y = iy; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x = $urandom;
    y = $urandom;
    u = 1'($urandom_range(1));
  endtask

  // From cycle 1: busy in cycles 1..33, results with done in cycle 34.
  // pulse_at != 0 raises start (with other operands) in that cycle.
  task automatic finish_op(input string tag, input logic [31:0] eq, input logic [31:0] er,
                           input logic edz, input int unsigned pulse_at);
    for (int unsigned c = 1; c <= 33; c++) begin
      chk($sformatf("%s busy/done c%0d", tag, c), {30'b0, busy, done}, 32'h2);
      if (c == pulse_at) begin
        start = 1'b1; u = 1'b0; x = 32'd50; y = 32'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk({tag, " busy/done c34"}, {30'b0, busy, done}, 32'h1);
    chk({tag, " quot"}, quot, eq);
    chk({tag, " rem"}, rem, er);
    chk({tag, " dz"}, {31'b0, dz}, {31'b0, edz});
  endtask

  // One cycle after done: idle, results still held.
  task automatic after_done(input string tag, input logic [31:0] eq, input logic [31:0] er);
    @(posedge clk); #1;
    chk({tag, " idle busy/done"}, {30'b0, busy, done}, 32'h0);
    chk({tag, " held quot"}, quot, eq);
    chk({tag, " held rem"}, rem, er);
  endtask

  task automatic op(input string tag, input logic iu, input logic [31:0] ix, input logic [31:0] iy,
                    input logic [31:0] eq, input logic [31:0] er, input logic edz);
    launch(iu, ix, iy);
    finish_op(tag, eq, er, edz, 0);
    after_done(tag, eq, er);
  endtask

  initial begin
    logic saw_done;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; start = 1'b0; u = 1'b0; x = '0; y = '0;

    @(posedge clk); @(posedge clk); #1;
    chk("reset busy/done", {30'b0, busy, done}, 32'h0);
    chk("reset dz", {31'b0, dz}, 32'h0);
    chk("reset quot", quot, 32'h0);
    chk("reset rem", rem, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    op("u 100/7",       1'b1, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0);
    op("s -7/2",        1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFC, 32'd1,        1'b0);
    op("s 7/-2",        1'b0, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFC, 32'hFFFFFFFF, 1'b0);
    op("s -7/-2",       1'b0, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0);
    op("s -8/2",        1'b0, 32'hFFFFFFF8, 32'd2,        32'hFFFFFFFC, 32'd0,        1'b0);
    op("s min/-1",      1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0);
    op("u max/1",       1'b1, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0);
    op("u 7/0xFFFFFFFE",1'b1, 32'd7,        32'hFFFFFFFE, 32'd0,        32'd7,        1'b0);

    // Start during busy is ignored; start in the done cycle is accepted.
    launch(1'b1, 32'd100, 32'd7);
    finish_op("ignore start", 32'd14, 32'd2, 1'b0, 10);
    launch(1'b0, 32'hFFFFFFF9, 32'hFFFFFFFE);
    finish_op("back-to-back", 32'd3, 32'hFFFFFFFF, 1'b0, 0);
    after_done("back-to-back", 32'd3, 32'hFFFFFFFF);

    op("u 1234/0",      1'b1, 32'd1234,     32'd0,        32'hFFFFFFFF, 32'd1234,     1'b1);
    op("s 1234/0",      1'b0, 32'd1234,     32'd0,        32'hFFFFFFFF, 32'd1234,     1'b1);
    op("s -1234/0",     1'b0, 32'hFFFFFB2E, 32'd0,        32'hFFFFFFFF, 32'hFFFFFB2E, 1'b1);

    // Reset in cycle 15 of an operation clears outputs immediately.
    launch(1'b1, 32'd1000, 32'd3);
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
    end
    chk("pre-reset busy", {31'b0, busy}, 32'h1);
    rst = 1'b1;
    #1;
    chk("async reset busy/done", {30'b0, busy, done}, 32'h0);
    chk("async reset dz", {31'b0, dz}, 32'h0);
    chk("async reset quot", quot, 32'h0);
    chk("async reset rem", rem, 32'h0);
    @(posedge clk); #3;
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    chk("no activity after abort", {31'b0, saw_done}, 32'h0);

    op("u 1000/3 after reset", 1'b1, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative signed/unsigned integer divider for the RISC5 CPU execute stage. It takes both operands straight from the register file read ports and computes quotient and remainder over a fixed 34-cycle sequence. The CPU holds its pipeline while `busy` is high and writes `quot` or `rem` back through the register file write port in the `done` cycle. Signed mode uses Oberon floored semantics: the remainder takes the sign of the divisor.

## Interface
- `WIDTH`, 32, operand/result width; the latency below assumes 32
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  begin division; sampled only when not busy
- `u`  in  1  1 = unsigned, 0 = signed floored; sampled with `start`
- `x`  in  WIDTH  dividend; sampled with `start`
- `y`  in  WIDTH  divisor; sampled with `start`
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle pulse, results valid
- `dz`  out  1  last operation had `y == 0`
- `quot`  out  WIDTH  quotient, held until next accepted start
- `rem`  out  WIDTH  remainder, held until next accepted start

## Operation
- States:
  - IDLE → CALC on `start`: latch `u`, sign bits, |x|, |y| (magnitudes unsigned in WIDTH bits), clear count.
  - CALC: 32 restoring steps, one bit per cycle, MSB first. The partial remainder is WIDTH+1 bits; trial subtract of |y| keeps the result when non-negative.
  - After 32 steps → FIX: apply sign correction, register `quot`/`rem`/`dz`.
  - FIX → DONE.
  - DONE → IDLE, or → CALC if `start` is high in DONE.
- Unsigned (`u=1`): `q = x / y`, `r = x % y`.
- Signed (`u=0`), with qa, ra the magnitude results:
  - Signs equal: `q = qa`, `r = ra` if y ≥ 0, else `−ra`.
  - Signs differ, ra = 0: `q = −qa`, `r = 0`.
  - Signs differ, ra ≠ 0: `q = −qa − 1`, `r = |y| − ra` if y > 0, else `ra − |y|`.
- `0x80000000 / −1` signed: `q = 0x80000000`, `r = 0`, no flag. This falls out naturally, with no special case.
- `y == 0`, either mode: `q = all-ones`, `r = x`, `dz = 1`, same latency.
- All arithmetic is modulo 2^WIDTH. Negation is two's complement.

## Timing
- Cycle 0 is the cycle in which `start` is sampled high in IDLE or DONE.
- `busy` is high in cycles 1–33 and low in cycle 34.
- `done` is high in cycle 34 only. `quot`/`rem`/`dz` are valid from cycle 34 and stable until the cycle after the next accepted start.
- `start` while `busy` is ignored. Operands are not re-sampled.
- `start` in the `done` cycle is accepted (back-to-back). The next `done` falls in cycle 34 relative to it.
- Operand changes after cycle 0 have no effect.
- Reset values: state IDLE, `busy=0`, `done=0`, `dz=0`, `quot=0`, `rem=0`, counter 0.
- Reset asserted mid-operation aborts immediately and asynchronously to the above values. No `done` is produced for the aborted operation.

## Structure
- Package `seq_divider_pkg`: state encoding (IDLE, CALC, FIX, DONE), step-count constant 32, counter width 6.
- One sub-module, `div_step`: combinational single restoring step. It takes the partial remainder, the next dividend bit and the divisor, and returns the new partial remainder and the quotient bit.
- The FSM, operand registers and sign correction live in the top level. Target is about 200 lines of RTL.

## Test plan
- Unsigned: `u=1`, x=100, y=7 → `busy` high in cycles 1–33; `done` in cycle 34; `quot=14`, `rem=2`, `dz=0`.
- Signed floor:
  - `u=0`, x=−7, y=2 → quot=0xFFFFFFFC, rem=1.
  - x=7, y=−2 → quot=0xFFFFFFFC, rem=0xFFFFFFFF.
  - x=−7, y=−2 → quot=3, rem=0xFFFFFFFF.
  - x=−8, y=2 → quot=0xFFFFFFFC, rem=0.
- Corner cases:
  - `u=0`, x=0x80000000, y=0xFFFFFFFF → quot=0x80000000, rem=0, dz=0.
  - `u=1`, x=0xFFFFFFFF, y=1 → quot=0xFFFFFFFF, rem=0.
- Divide by zero: x=1234, y=0, either `u` → quot=0xFFFFFFFF, rem=1234, dz=1, `done` in cycle 34.
- Handshake:
  - `start` pulsed in cycle 10 of a running operation → ignored; results belong to the first operands.
  - New `start` in the `done` cycle → second `done` exactly 34 cycles later with correct results.
- Reset mid-operation: assert `rst` in cycle 15 → all outputs 0 immediately. After release, no `done` appears until a new `start`, which then completes normally.
